// File: rtl/fdc_meas_ctrl_if.sv
// Purpose : bundles the control, pin and result signals of the FDC measurement sequencer.
// Latency : n/a (wiring only).
// Backpressure: none; start is a level sampled by the sequencer while idle.
//
// Ports (sequencer side, modport slave):
//   in  start, cont, abort, chan_req, win_len[WIN_W], ref_in, vco_in
//   out sel_out, fdc_rst, busy, result[CNT_W], result_valid, overflow
interface fdc_meas_ctrl_if #(
    parameter int CNT_W = 5,
    parameter int WIN_W = 8
);
    logic             start;
    logic             cont;
    logic             abort;
    logic             chan_req;
    logic [WIN_W-1:0] win_len;
    logic             ref_in;
    logic             vco_in;
    logic             sel_out;
    logic             fdc_rst;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             overflow;

    modport slave (
        input  start, cont, abort, chan_req, win_len, ref_in, vco_in,
        output sel_out, fdc_rst, busy, result, result_valid, overflow
    );

    modport master (
        output start, cont, abort, chan_req, win_len, ref_in, vco_in,
        input  sel_out, fdc_rst, busy, result, result_valid, overflow
    );
endinterface

// File: rtl/fdc_meas_ctrl.sv
// Purpose : FDC measurement sequencer: select channel, settle under reset, gate VCO edges over win_len ref periods.
// Latency : SETTLE cycles + wait for ref edge + win_len ref periods + 1 DONE cycle; pin edges seen 2-3 clk late.
// Backpressure: none; start ignored while busy, abort returns to IDLE from any state.
//
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   bus (slave)   : start/cont/abort/chan_req/win_len controls, async ref_in/vco_in pins,
//                   sel_out/fdc_rst to the FDC core, busy, result/overflow with result_valid strobe
module fdc_meas_ctrl #(
    parameter int CNT_W  = 5,
    parameter int WIN_W  = 8,
    parameter int SETTLE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fdc_meas_ctrl_if.slave bus
);

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_ARM,
        S_GATE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Pin synchronizers: [0],[1] are the two metastability stages, [2] is history.
    logic [2:0] ref_sh;
    logic [2:0] vco_sh;
    logic       ref_pulse;
    logic       vco_pulse;

    logic             sel_q;
    logic [WIN_W-1:0] win_lat;
    logic [7:0]       settle_cnt;
    logic [WIN_W-1:0] ref_cnt;
    logic [WIN_W-1:0] ref_cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic [CNT_W-1:0] result_q;
    logic             overflow_q;

    logic load_cfg;
    logic settle_done;
    logic gate_close;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_sh <= '0;
            vco_sh <= '0;
        end else begin
            ref_sh <= {ref_sh[1:0], bus.ref_in};
            vco_sh <= {vco_sh[1:0], bus.vco_in};
        end
    end

    assign ref_pulse = ref_sh[1] & ~ref_sh[2];
    assign vco_pulse = vco_sh[1] & ~vco_sh[2];

    // Channel and gate length are captured only when SETTLE is entered, so the
    // core always leaves reset with the select it settled on.
    assign load_cfg = !bus.abort &&
                      ((state == S_IDLE && bus.start) || (state == S_DONE && bus.cont));

    assign settle_done = (settle_cnt == SETTLE_LAST);
    assign ref_cnt_inc = ref_cnt + WIN_W'(1);
    assign gate_close  = (state == S_GATE) && ref_pulse && (ref_cnt_inc == win_lat);

    // Saturating count; a VCO pulse in the closing cycle is still folded in.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (vco_pulse) begin
            if (cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next-state logic; abort outranks every other input
    always_comb begin
        state_nxt = state;
        if (bus.abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (bus.start) state_nxt = S_SETTLE;
                S_SETTLE: if (settle_done) state_nxt = S_ARM;
                S_ARM:    if (ref_pulse) state_nxt = S_GATE;
                S_GATE:   if (gate_close) state_nxt = S_DONE;
                S_DONE:   state_nxt = bus.cont ? S_SETTLE : S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // FSM: Moore outputs
    always_comb begin
        bus.busy         = 1'b1;
        bus.fdc_rst      = 1'b1;
        bus.result_valid = 1'b0;
        case (state)
            S_IDLE:   bus.busy = 1'b0;
            S_ARM:    bus.fdc_rst = 1'b0;
            S_GATE:   bus.fdc_rst = 1'b0;
            S_DONE:   bus.result_valid = 1'b1;
            default:  ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= 1'b0;
            win_lat    <= WIN_W'(1);
            settle_cnt <= '0;
            ref_cnt    <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (load_cfg) begin
                sel_q      <= bus.chan_req;
                win_lat    <= (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
                settle_cnt <= '0;
            end else if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt + 8'd1;
            end

            // The opening ref edge only clears; its coincident VCO pulse is dropped.
            if (state == S_ARM && ref_pulse) begin
                cnt     <= '0;
                ovf     <= 1'b0;
                ref_cnt <= '0;
            end else if (state == S_GATE) begin
                cnt <= cnt_nxt;
                ovf <= ovf_nxt;
                if (ref_pulse) begin
                    ref_cnt <= ref_cnt_inc;
                end
            end

            // Publish on the edge into DONE so result is stable while result_valid is high.
            if (gate_close && !bus.abort) begin
                result_q   <= cnt_nxt;
                overflow_q <= ovf_nxt;
            end
        end
    end

    assign bus.sel_out  = sel_q;
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_fdc_meas_ctrl.sv
// Purpose : directed self-checking bench for fdc_meas_ctrl.
// Latency : n/a.
// Backpressure: n/a.
module tb_fdc_meas_ctrl;
    localparam int CNT_W  = 5;
    localparam int WIN_W  = 8;
    localparam int SETTLE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fdc_meas_ctrl_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    fdc_meas_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Pin waveforms in clk-period units; 0 holds the pin low.
    int ref_per = 0;
    int vco_per = 0;
    int ph      = 0;

    initial begin
        bus.ref_in = 1'b0;
        bus.vco_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            ph++;
            bus.ref_in = (ref_per > 0) && ((ph % ref_per) < (ref_per / 2));
            bus.vco_in = (vco_per > 0) && ((ph % vco_per) < (vco_per / 2));
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            cycles = i + 1;
            if (bus.result_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.start = 0; bus.cont = 0; bus.abort = 0; bus.chan_req = 0; bus.win_len = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.fdc_rst !== 1'b1 || bus.sel_out !== 1'b0 ||
            bus.result !== 5'd0 || bus.result_valid !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b fdc_rst=%b sel=%b result=%0d rv=%b ovf=%b, need 0 1 0 0 0 0",
                     bus.busy, bus.fdc_rst, bus.sel_out, bus.result, bus.result_valid, bus.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.fdc_rst !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b fdc_rst=%b, need 0 1", bus.busy, bus.fdc_rst);
        end
    endtask

    task automatic test_settle();
        int n;
        ref_per = 0; vco_per = 0;
        bus.chan_req = 1'b1; bus.win_len = 8'd4;
        pulse_start();
        checks++;
        if (bus.sel_out !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL settle_entry: sel=%b busy=%b, need 1 1", bus.sel_out, bus.busy);
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.fdc_rst !== 1'b1) break;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != SETTLE) begin
            errors++;
            $display("FAIL settle_len: got %0d cycles with fdc_rst high, need %0d", n, SETTLE);
        end
        // No ref edges: parked in ARM with the core released.
        repeat (5) @(negedge clk);
        checks++;
        if (bus.fdc_rst !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL arm_wait: fdc_rst=%b busy=%b, need 0 1", bus.fdc_rst, bus.busy);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.fdc_rst !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_arm: busy=%b fdc_rst=%b rv=%b, need 0 1 0", bus.busy, bus.fdc_rst, bus.result_valid);
        end
    endtask

    task automatic test_single_shot();
        bit got; int cyc;
        ref_per = 20; vco_per = 6;
        bus.chan_req = 1'b1; bus.win_len = 8'd4; bus.cont = 1'b0;
        pulse_start();
        wait_valid(200, got, cyc);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL single_timeout: no result_valid within 200 cycles");
        end
        checks++;
        if ($isunknown(bus.result) || bus.result < 5'd13 || bus.result > 5'd14 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL single_result: result=%0d ovf=%b, need 13..14 ovf 0", bus.result, bus.overflow);
        end
        checks++;
        if (cyc + 1 < 84 || cyc + 1 > 110) begin
            errors++;
            $display("FAIL single_busy_len: busy %0d cycles, need 84..110", cyc + 1);
        end
        @(negedge clk);
        checks++;
        if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0 || bus.fdc_rst !== 1'b1) begin
            errors++;
            $display("FAIL single_end: rv=%b busy=%b fdc_rst=%b, need 0 0 1", bus.result_valid, bus.busy, bus.fdc_rst);
        end
    endtask

    task automatic test_win_zero();
        bit got; int cyc;
        ref_per = 20; vco_per = 4;
        bus.chan_req = 1'b0; bus.win_len = 8'd0;
        pulse_start();
        wait_valid(200, got, cyc);
        checks++;
        if (!got || $isunknown(bus.result) || bus.result < 5'd4 || bus.result > 5'd6) begin
            errors++;
            $display("FAIL win_zero_result: got=%b result=%0d, need valid with 4..6", got, bus.result);
        end
        checks++;
        if (cyc + 1 > 52) begin
            errors++;
            $display("FAIL win_zero_len: busy %0d cycles, need <=52 (one ref period)", cyc + 1);
        end
        checks++;
        if (bus.sel_out !== 1'b0) begin
            errors++;
            $display("FAIL win_zero_sel: sel=%b, need 0", bus.sel_out);
        end
        @(negedge clk);
    endtask

    task automatic test_continuous();
        bit got; bit sel_bad; bit exp_sel; int cyc;
        ref_per = 20; vco_per = 6;
        bus.win_len = 8'd2; bus.cont = 1'b1; bus.chan_req = 1'b1;
        exp_sel = 1'b1;
        pulse_start();
        bus.chan_req = 1'b0;   // changes mid-run must not reach sel_out
        for (int run = 0; run < 3; run++) begin
            got = 1'b0; sel_bad = 1'b0;
            for (int i = 0; i < 150 && !got; i++) begin
                if (bus.sel_out !== exp_sel) sel_bad = 1'b1;
                @(negedge clk);
                if (bus.result_valid === 1'b1) got = 1'b1;
            end
            checks++;
            if (!got || sel_bad || bus.sel_out !== exp_sel) begin
                errors++;
                $display("FAIL cont_run%0d_sel: got=%b sel_bad=%b sel=%b, need valid, stable sel %b",
                         run, got, sel_bad, bus.sel_out, exp_sel);
            end
            checks++;
            if ($isunknown(bus.result) || bus.result < 5'd6 || bus.result > 5'd7) begin
                errors++;
                $display("FAIL cont_run%0d_result: result=%0d, need 6..7", run, bus.result);
            end
            // chan_req currently holds ~exp_sel; DONE latches it if cont is still high.
            if (run < 2) exp_sel = ~exp_sel;
            @(negedge clk);
            checks++;
            if (run < 2) begin
                if (bus.busy !== 1'b1 || bus.fdc_rst !== 1'b1 || bus.result_valid !== 1'b0 ||
                    bus.sel_out !== exp_sel) begin
                    errors++;
                    $display("FAIL cont_rearm%0d: busy=%b fdc_rst=%b rv=%b sel=%b, need 1 1 0 %b",
                             run, bus.busy, bus.fdc_rst, bus.result_valid, bus.sel_out, exp_sel);
                end
                bus.chan_req = ~exp_sel;
                if (run == 1) bus.cont = 1'b0;
            end else begin
                if (bus.busy !== 1'b0 || bus.sel_out !== exp_sel) begin
                    errors++;
                    $display("FAIL cont_stop: busy=%b sel=%b, need 0 %b", bus.busy, bus.sel_out, exp_sel);
                end
            end
        end
        got = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1 || bus.busy === 1'b1) got = 1'b1;
        end
        checks++;
        if (got) begin
            errors++;
            $display("FAIL cont_no_rerun: activity after cont dropped, need none");
        end
    endtask

    task automatic test_overflow();
        bit got; int cyc;
        ref_per = 40; vco_per = 2;
        bus.chan_req = 1'b1; bus.win_len = 8'd4; bus.cont = 1'b0;
        pulse_start();
        wait_valid(300, got, cyc);
        checks++;
        if (!got || bus.result !== 5'd31 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: got=%b result=%0d ovf=%b, need valid 31 1", got, bus.result, bus.overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_abort_gate();
        bit seen;
        ref_per = 20; vco_per = 6;
        bus.chan_req = 1'b1; bus.win_len = 8'd4;
        pulse_start();
        repeat (40) @(negedge clk);
        checks++;
        if (bus.fdc_rst !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: fdc_rst=%b busy=%b, need 0 1", bus.fdc_rst, bus.busy);
        end
        // start while busy must neither reload the channel nor queue a run
        bus.chan_req = 1'b0;
        pulse_start();
        checks++;
        if (bus.sel_out !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_sel: sel=%b, need 1", bus.sel_out);
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.fdc_rst !== 1'b1 || bus.result_valid !== 1'b0 ||
            bus.result !== 5'd31 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL abort_gate: busy=%b fdc_rst=%b rv=%b result=%0d ovf=%b, need 0 1 0 31 1",
                     bus.busy, bus.fdc_rst, bus.result_valid, bus.result, bus.overflow);
        end
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_quiet: activity after abort, need none");
        end
    endtask

    task automatic test_overflow_clear();
        bit got; int cyc;
        ref_per = 20; vco_per = 6;
        bus.chan_req = 1'b0; bus.win_len = 8'd4;
        pulse_start();
        wait_valid(200, got, cyc);
        checks++;
        if (!got || bus.overflow !== 1'b0 || $isunknown(bus.result) ||
            bus.result < 5'd13 || bus.result > 5'd14) begin
            errors++;
            $display("FAIL overflow_clear: got=%b result=%0d ovf=%b, need valid 13..14 0",
                     got, bus.result, bus.overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        bit got; int cyc;
        ref_per = 20; vco_per = 6;
        bus.chan_req = 1'b1; bus.win_len = 8'd4;
        pulse_start();
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.fdc_rst !== 1'b1 || bus.sel_out !== 1'b0 ||
            bus.result !== 5'd0 || bus.result_valid !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: busy=%b fdc_rst=%b sel=%b result=%0d rv=%b ovf=%b, need 0 1 0 0 0 0",
                     bus.busy, bus.fdc_rst, bus.sel_out, bus.result, bus.result_valid, bus.overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_valid(200, got, cyc);
        checks++;
        if (!got || bus.sel_out !== 1'b1 || bus.overflow !== 1'b0 || $isunknown(bus.result) ||
            bus.result < 5'd13 || bus.result > 5'd14) begin
            errors++;
            $display("FAIL post_reset_run: got=%b sel=%b result=%0d ovf=%b, need valid 1 13..14 0",
                     got, bus.sel_out, bus.result, bus.overflow);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_settle();
        test_single_shot();
        test_win_zero();
        test_continuous();
        test_overflow();
        test_abort_gate();
        test_overflow_clear();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
